spi_mult_ctrl: RTL and testbench

Frame-level sequencer for the SPI multiplier peripheral. It watches conditioned chip-select and single-cycle SCLK edge pulses, and counts bits. It strobes the operand-register enables, starts the 4x4 multiplier and waits for its done flag. It then parallel-loads the 8-bit product into the shift register and gates the MISO buffer while the product is shifted out. It sits between the input conditioners and the shift register / A,B registers / multiplier / MISO AND gate.

---
 rtl/spi_mult_ctrl_if.sv | 32 +++
 rtl/spi_mult_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_spi_mult_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mult_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_mult_ctrl_if
// Purpose  : Frame-sequencer bus: conditioned SPI events in, datapath strobes out.
// Revision : 1.0
// ============================================================================
interface spi_mult_ctrl_if;
  logic cs_con;
  logic sclk_pos;
  logic sclk_neg;
  logic mult_done;
  logic a_en;
  logic b_en;
  logic mult_start;
  logic sr_we;
  logic miso_en;
  logic busy;
  logic err;

  // master: conditioners / multiplier side that feeds the sequencer
  modport master (
    output cs_con, sclk_pos, sclk_neg, mult_done,
    input  a_en, b_en, mult_start, sr_we, miso_en, busy, err
  );

  // slave: the sequencer itself
  modport slave (
    input  cs_con, sclk_pos, sclk_neg, mult_done,
    output a_en, b_en, mult_start, sr_we, miso_en, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/spi_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_mult_ctrl
// Purpose  : Frame sequencer for the SPI 4x4 multiplier (operand capture,
//            multiply, product load and shift-out gating).
// Revision : 1.0
// ============================================================================
module spi_mult_ctrl #(
  parameter int FRAME_BITS = 8,
  parameter int TIMEOUT    = 16,
  parameter int TO_W       = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  spi_mult_ctrl_if.slave     bus
);

  localparam int                CNT_W    = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_A = 3'd1,
    GET_B = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    LOAD  = 3'd5,
    SEND  = 3'd6,
    HOLD  = 3'd7
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             a_en;
  logic             b_en;
  logic             mult_start;
  logic             sr_we;
  logic             miso_en;
  logic             busy;
  logic             err;

  logic             byte_done;
  logic             cs_abort;
  logic [CNT_W-1:0] bit_next;

  assign byte_done = bus.sclk_pos && (bit_cnt == LAST_BIT);
  assign cs_abort  = (state != IDLE) && bus.cs_con;
  assign bit_next  = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      a_en       <= 1'b0;
      b_en       <= 1'b0;
      mult_start <= 1'b0;
      sr_we      <= 1'b0;
      miso_en    <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      a_en       <= 1'b0;
      b_en       <= 1'b0;
      mult_start <= 1'b0;
      sr_we      <= 1'b0;

      if (cs_abort) begin
        // CS released mid-sequence: only a frame parked in HOLD ended cleanly
        state   <= IDLE;
        busy    <= 1'b0;
        miso_en <= 1'b0;
        bit_cnt <= '0;
        to_cnt  <= '0;
        if (state != HOLD) begin
          err <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (!bus.cs_con) begin
              state   <= GET_A;
              busy    <= 1'b1;
              bit_cnt <= '0;
              to_cnt  <= '0;
              err     <= 1'b0;
            end
          end

          GET_A: begin
            if (bus.sclk_pos) begin
              bit_cnt <= bit_next;
            end
            if (byte_done) begin
              a_en  <= 1'b1;
              state <= GET_B;
            end
          end

          GET_B: begin
            if (bus.sclk_pos) begin
              bit_cnt <= bit_next;
            end
            if (byte_done) begin
              b_en  <= 1'b1;
              state <= START;
            end
          end

          // START spans two cycles so operand B is settled a full cycle before mult_start
          START: begin
            if (bus.sclk_pos) begin
              err <= 1'b1;
            end
            if (!b_en) begin
              mult_start <= 1'b1;
              to_cnt     <= '0;
              state      <= WAIT;
            end
          end

          WAIT: begin
            if (bus.sclk_pos) begin
              err <= 1'b1;
            end
            if (bus.mult_done) begin
              sr_we   <= 1'b1;
              bit_cnt <= '0;
              to_cnt  <= '0;
              state   <= LOAD;
            end else if (to_cnt == TO_LAST) begin
              err    <= 1'b1;
              to_cnt <= '0;
              state  <= HOLD;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end

          LOAD: begin
            if (bus.sclk_pos) begin
              err <= 1'b1;
            end
            bit_cnt <= '0;
            miso_en <= 1'b1;
            state   <= SEND;
          end

          SEND: begin
            if (bus.sclk_pos) begin
              bit_cnt <= bit_next;
            end
            if (byte_done) begin
              miso_en <= 1'b0;
              state   <= HOLD;
            end else begin
              miso_en <= miso_en | bus.sclk_neg;
            end
          end

          HOLD: begin
            miso_en <= 1'b0;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.a_en       = a_en;
  assign bus.b_en       = b_en;
  assign bus.mult_start = mult_start;
  assign bus.sr_we      = sr_we;
  assign bus.miso_en    = miso_en;
  assign bus.busy       = busy;
  assign bus.err        = err;

endmodule
`default_nettype wire

// File: tb/tb_spi_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_mult_ctrl
// Purpose  : Self-checking bench: frame scenarios scored against event-timing model.
// Revision : 1.0
// ============================================================================
module tb_spi_mult_ctrl;

  localparam int A  = 6;
  localparam int B  = 5;
  localparam int ST = 4;
  localparam int SR = 3;
  localparam int MI = 2;
  localparam int BZ = 1;
  localparam int ER = 0;
  localparam int TIMEOUT_CYC = 16;

  logic clk;
  logic reset_n;
  spi_mult_ctrl_if bus ();

  spi_mult_ctrl #(
    .FRAME_BITS (8),
    .TIMEOUT    (TIMEOUT_CYC),
    .TO_W       (5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] outs;
  assign outs = {bus.a_en, bus.b_en, bus.mult_start, bus.sr_we, bus.miso_en, bus.busy, bus.err};

  typedef struct {
    int abort_bits;   // -1: full frame, else CS rises after this many bits of byte A
    int done_delay;   // cycles from mult_start to mult_done; -1: never (timeout)
    bit stray;        // one sclk_pos while waiting for the multiplier
    int gap_after;    // extra CS-high cycles after the frame
    bit exp_err;      // err level when CS returns high
  } vec_t;

  logic [6:0] hist [$];
  int n;
  int nchk;
  int nfail;
  int frame_no;

  task automatic step();
    @(posedge clk);
    #1;
    hist.push_back(outs);
    n = hist.size() - 1;
  endtask

  task automatic idle(input int k);
    bus.sclk_pos = 1'b0;
    bus.sclk_neg = 1'b0;
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic send_bit(output int p);
    idle($urandom_range(0, 2));
    bus.sclk_neg = 1'b1;
    step();
    bus.sclk_neg = 1'b0;
    idle($urandom_range(0, 1));
    bus.sclk_pos = 1'b1;
    step();
    bus.sclk_pos = 1'b0;
    p = n;
  endtask

  task automatic check_now(input string name, input logic [6:0] got, input logic [6:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s (frame %0d): outputs %b, required %b", name, frame_no, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input int idx, input int bp, input logic exp);
    nchk++;
    if (hist[idx][bp] !== exp) begin
      nfail++;
      $display("FAIL %s (frame %0d): step %0d value %b, required %b",
               name, frame_no, idx, hist[idx][bp], exp);
    end
  endtask

  task automatic check_pulse(input string name, input int bp, input int lo, input int hi, input int exp);
    int cnt;
    int first;
    cnt   = 0;
    first = -1;
    for (int i = lo; i <= hi; i++) begin
      if (hist[i][bp] !== 1'b0) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    nchk++;
    if ((exp < 0) ? (cnt != 0) : (cnt != 1 || first != exp)) begin
      nfail++;
      $display("FAIL %s (frame %0d): %0d pulse(s), first at step %0d; required single pulse at step %0d (-1 = none)",
               name, frame_no, cnt, first, exp);
    end
  endtask

  task automatic check_range(input string name, input int bp, input int lo, input int hi,
                             input int elo, input int ehi);
    int bad;
    int first_bad;
    logic e;
    bad       = 0;
    first_bad = -1;
    for (int i = lo; i <= hi; i++) begin
      e = (i >= elo && i <= ehi);
      if (hist[i][bp] !== e) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    nchk++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL %s (frame %0d): %0d wrong cycle(s), first at step %0d value %b; required high on steps %0d..%0d",
               name, frame_no, bad, first_bad, hist[first_bad][bp], elo, ehi);
    end
  endtask

  task automatic check_excl(input int lo, input int hi);
    int bad;
    bad = 0;
    for (int i = lo; i <= hi; i++) begin
      if ($countones(hist[i][6:3]) > 1) bad++;
    end
    nchk++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL strobe_exclusive (frame %0d): %0d cycle(s) with overlapping strobes, required 0",
               frame_no, bad);
    end
  endtask

  // Expected event steps follow directly from the frame rules: enables one cycle
  // after the byte-complete edge, mult_start two cycles after b_en, and so on.
  task automatic run_frame(input vec_t v);
    int e, c, pa, pb, ms, d, s8, h, nb;
    frame_no++;
    bus.cs_con = 1'b0;
    idle(1);
    e = n;
    check_bit("err_clear_on_cs_fall", e, ER, 1'b0);

    nb = (v.abort_bits >= 0) ? v.abort_bits : 8;
    pa = -1;
    for (int i = 0; i < nb; i++) send_bit(pa);

    if (v.abort_bits >= 0) begin
      idle(1);
      bus.cs_con = 1'b1;
      idle(1);
      c = n;
      check_pulse("abort_no_a_en", A, e, c, -1);
      check_pulse("abort_no_b_en", B, e, c, -1);
      check_pulse("abort_no_start", ST, e, c, -1);
      check_range("abort_busy", BZ, e, c, e, c - 1);
      check_range("abort_err", ER, e, c, c, c);
      check_bit("abort_err_end", c, ER, v.exp_err);
      check_excl(e, c);
      idle(v.gap_after);
      return;
    end

    for (int i = 0; i < 8; i++) send_bit(pb);
    ms = pb + 2;
    idle(ms - n);
    if (v.stray) begin
      bus.sclk_pos = 1'b1;
      step();
      bus.sclk_pos = 1'b0;
    end

    if (v.done_delay >= 0) begin
      d = ms + 1 + v.done_delay;
      idle(d - 1 - n);
      bus.mult_done = 1'b1;
      step();
      bus.mult_done = 1'b0;
      idle(1);
      for (int i = 0; i < 8; i++) send_bit(s8);
      idle(1 + $urandom_range(0, 2));
      bus.cs_con = 1'b1;
      idle(1);
      h = n;
      check_pulse("sr_we", SR, e, h, d);
      check_range("miso_en", MI, e, h, d + 1, s8 - 1);
      if (v.stray) check_range("stray_err", ER, e, h, ms + 1, h);
      else         check_range("err_clean", ER, e, h, h + 1, h);
    end else begin
      idle(ms + 20 - n);
      bus.cs_con = 1'b1;
      idle(1);
      h = n;
      check_pulse("timeout_no_sr_we", SR, e, h, -1);
      check_range("timeout_miso_off", MI, e, h, h + 1, h);
      check_range("timeout_err", ER, e, h, ms + TIMEOUT_CYC, h);
    end

    check_pulse("a_en", A, e, h, pa);
    check_pulse("b_en", B, e, h, pb);
    check_pulse("mult_start", ST, e, h, ms);
    check_range("busy", BZ, e, h, e, h - 1);
    check_bit("err_at_frame_end", h, ER, v.exp_err);
    check_excl(e, h);
    idle(v.gap_after);
  endtask

  vec_t vecs [8];
  vec_t rv;
  int   r;
  int   pdum;

  initial begin
    nchk     = 0;
    nfail    = 0;
    frame_no = 0;
    n        = -1;
    reset_n       = 1'b0;
    bus.cs_con    = 1'b1;
    bus.sclk_pos  = 1'b0;
    bus.sclk_neg  = 1'b0;
    bus.mult_done = 1'b0;

    vecs[0] = '{abort_bits: -1, done_delay:  4, stray: 1'b0, gap_after: 3, exp_err: 1'b0};
    vecs[1] = '{abort_bits: -1, done_delay: -1, stray: 1'b0, gap_after: 2, exp_err: 1'b1};
    vecs[2] = '{abort_bits:  5, done_delay:  4, stray: 1'b0, gap_after: 2, exp_err: 1'b1};
    vecs[3] = '{abort_bits: -1, done_delay:  4, stray: 1'b1, gap_after: 2, exp_err: 1'b1};
    vecs[4] = '{abort_bits: -1, done_delay:  2, stray: 1'b0, gap_after: 0, exp_err: 1'b0};
    vecs[5] = '{abort_bits: -1, done_delay:  0, stray: 1'b0, gap_after: 0, exp_err: 1'b0};
    vecs[6] = '{abort_bits: -1, done_delay: 14, stray: 1'b0, gap_after: 1, exp_err: 1'b0};
    vecs[7] = '{abort_bits:  0, done_delay:  4, stray: 1'b0, gap_after: 1, exp_err: 1'b1};

    @(posedge clk);
    #1;
    check_now("reset_outputs", outs, 7'b0);
    reset_n = 1'b1;
    idle(2);
    check_bit("idle_not_busy", n, BZ, 1'b0);

    for (int k = 0; k < 8; k++) run_frame(vecs[k]);

    for (int k = 0; k < 10; k++) begin
      r  = $urandom_range(0, 9);
      rv = '{abort_bits: -1, done_delay: $urandom_range(0, 12), stray: 1'b0,
             gap_after: $urandom_range(0, 3), exp_err: 1'b0};
      if (r == 0) rv.abort_bits = $urandom_range(0, 7);
      if (r == 1) rv.done_delay = -1;
      if (r == 2) begin
        rv.stray      = 1'b1;
        rv.done_delay = $urandom_range(1, 12);
      end
      rv.exp_err = (rv.abort_bits >= 0) || (rv.done_delay < 0) || rv.stray;
      run_frame(rv);
    end

    // Asynchronous reset while shifting the product out
    frame_no++;
    bus.cs_con = 1'b0;
    idle(1);
    for (int i = 0; i < 16; i++) send_bit(pdum);
    idle(5);
    bus.mult_done = 1'b1;
    step();
    bus.mult_done = 1'b0;
    idle(1);
    for (int i = 0; i < 3; i++) send_bit(pdum);
    check_bit("pre_reset_miso_en", n, MI, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_now("async_reset_outputs", outs, 7'b0);
    #2;
    reset_n = 1'b1;
    bus.cs_con = 1'b1;
    idle(1);
    check_bit("post_reset_idle", n, BZ, 1'b0);
    check_bit("post_reset_err", n, ER, 1'b0);
    idle(1);

    run_frame(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
`default_nettype wire
